// File: rtl/cpu_bus_arbiter_if.sv
// CPU-side request/ack bundle plus external bus pins for cpu_bus_arbiter.
// master = arbiter side, slave = requesters and bus slave side.
interface cpu_bus_arbiter_if;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_rdata;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        bus_err;
  logic [23:0] addr_o;
  logic        re_o;
  logic        we_o;
  logic [15:0] data_o;
  logic [15:0] data_i;
  logic        needWait_i;

  modport master (
    input  fetch_req, fetch_addr,
    input  mem_req, mem_addr, mem_we, mem_wdata,
    input  data_i, needWait_i,
    output fetch_ack, fetch_rdata,
    output mem_ack, mem_rdata, bus_err,
    output addr_o, re_o, we_o, data_o
  );

  modport slave (
    output fetch_req, fetch_addr,
    output mem_req, mem_addr, mem_we, mem_wdata,
    output data_i, needWait_i,
    input  fetch_ack, fetch_rdata,
    input  mem_ack, mem_rdata, bus_err,
    input  addr_o, re_o, we_o, data_o
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Fetch vs load/store arbiter for the single external memory bus.
// CPU_BUS_TIMEOUT_EN enables the wait-state abort counter and bus_err.
module cpu_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  cpu_bus_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1) begin : g_chk_starve
    $error("STARVE_LIMIT must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_chk_to
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    GNT_FETCH,
    GNT_MEM
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          f_ack_q, f_ack_d;
  logic          m_ack_q, m_ack_d;
  logic [15:0]   f_rdata_q, f_rdata_d;
  logic [15:0]   m_rdata_q, m_rdata_d;
  logic          done;
  logic          abort;

  assign done = (state_q != IDLE) && !bus.needWait_i;

`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  assign abort = (state_q != IDLE) && bus.needWait_i
              && (wait_q == 8'(TIMEOUT_CYCLES - 1));
  assign err_d = abort;

  // Counter is held at zero in IDLE, so every grant starts from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
    end else if (bus.needWait_i) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus.bus_err = err_q;
`else
  assign abort       = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    f_ack_d   = 1'b0;
    m_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    m_rdata_d = m_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_req && bus.mem_req) begin
          if (starve_q == SW'(STARVE_LIMIT)) begin
            state_d = GNT_FETCH;
          end else begin
            state_d = GNT_MEM;
          end
        end else if (bus.mem_req) begin
          state_d = GNT_MEM;
        end else if (bus.fetch_req) begin
          state_d = GNT_FETCH;
        end
        if (!bus.fetch_req) begin
          starve_d = '0;
        end else if (state_d == GNT_FETCH) begin
          starve_d = '0;
        end else if (state_d == GNT_MEM
                     && starve_q != SW'(STARVE_LIMIT)) begin
          starve_d = starve_q + SW'(1);
        end
      end
      GNT_FETCH: begin
        if (abort) begin
          f_ack_d   = 1'b1;
          f_rdata_d = 16'hFFFF;
          state_d   = IDLE;
        end else if (done) begin
          f_ack_d   = 1'b1;
          f_rdata_d = bus.data_i;
          state_d   = IDLE;
        end
      end
      GNT_MEM: begin
        if (abort) begin
          m_ack_d   = 1'b1;
          m_rdata_d = 16'hFFFF;
          state_d   = IDLE;
        end else if (done) begin
          m_ack_d = 1'b1;
          if (!bus.mem_we) begin
            m_rdata_d = bus.data_i;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      f_ack_q   <= 1'b0;
      m_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      f_ack_q   <= f_ack_d;
      m_ack_q   <= m_ack_d;
      f_rdata_q <= f_rdata_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  // Bus strobes depend only on the registered grant.
  always_comb begin
    bus.addr_o = '0;
    bus.re_o   = 1'b0;
    bus.we_o   = 1'b0;
    bus.data_o = '0;
    unique case (state_q)
      GNT_FETCH: begin
        bus.addr_o = bus.fetch_addr;
        bus.re_o   = 1'b1;
      end
      GNT_MEM: begin
        bus.addr_o = bus.mem_addr;
        bus.re_o   = !bus.mem_we;
        bus.we_o   = bus.mem_we;
        bus.data_o = bus.mem_wdata;
      end
      default: begin
        bus.addr_o = '0;
      end
    endcase
  end

  assign bus.fetch_ack   = f_ack_q;
  assign bus.mem_ack     = m_ack_q;
  assign bus.fetch_rdata = f_rdata_q;
  assign bus.mem_rdata   = m_rdata_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with an ack scoreboard.
// Covers reset, latency, starvation pattern, waits and timeout.
module tb_cpu_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_fetch;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_mem_rd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ack(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_fack"}, 32'(bus.fetch_ack), 32'(e.is_fetch));
    chk({tag, "_mack"}, 32'(bus.mem_ack), 32'(!e.is_fetch));
    if (e.is_fetch) chk({tag, "_frd"}, 32'(bus.fetch_rdata), 32'(e.rdata));
    else            chk({tag, "_mrd"}, 32'(bus.mem_rdata), 32'(e.rdata));
    chk({tag, "_err"}, 32'(bus.bus_err), 32'(e.err));
  endtask

  task automatic do_access(input string tag, input bit f,
                           input logic [23:0] a, input logic we,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int waits);
    exp_t e;
    if (f) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_addr  = a;
      bus.mem_we    = we;
      bus.mem_wdata = wd;
    end
    bus.data_i     = rd;
    bus.needWait_i = 1'b0;
    e.is_fetch = f;
    e.err      = 1'b0;
    if (!f && !we) exp_mem_rd = rd;
    e.rdata = f ? rd : exp_mem_rd;
    sb.push_back(e);
    tick;
    for (int k = 0; k <= waits; k++) begin
      chk({tag, "_addr"}, 32'(bus.addr_o), 32'(a));
      chk({tag, "_re"}, 32'(bus.re_o), 32'(f || !we));
      chk({tag, "_we"}, 32'(bus.we_o), 32'(!f && we));
      if (!f) chk({tag, "_wd"}, 32'(bus.data_o), 32'(wd));
      chk({tag, "_noack"}, 32'(bus.fetch_ack | bus.mem_ack), 32'(0));
      bus.needWait_i = (k < waits);
      tick;
    end
    check_ack(tag);
    bus.fetch_req  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.needWait_i = 1'b0;
    chk({tag, "_idle"}, 32'(bus.re_o | bus.we_o), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    int    n;
    int    acks;
    int    re_low;
    exp_t  e;

    rst            = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    bus.data_i     = '0;
    bus.needWait_i = 1'b0;
    exp_mem_rd     = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_re", 32'(bus.re_o), 32'(0));
    chk("rst_we", 32'(bus.we_o), 32'(0));
    chk("rst_addr", 32'(bus.addr_o), 32'(0));
    chk("rst_data", 32'(bus.data_o), 32'(0));
    chk("rst_fack", 32'(bus.fetch_ack), 32'(0));
    chk("rst_mack", 32'(bus.mem_ack), 32'(0));
    chk("rst_err", 32'(bus.bus_err), 32'(0));
    chk("rst_frd", 32'(bus.fetch_rdata), 32'(0));
    chk("rst_mrd", 32'(bus.mem_rdata), 32'(0));

    // reset in the middle of a waiting write
    bus.mem_req    = 1'b1;
    bus.mem_addr   = 24'h000055;
    bus.mem_we     = 1'b1;
    bus.mem_wdata  = 16'hCAFE;
    bus.needWait_i = 1'b1;
    tick;
    chk("midrst_we_before", 32'(bus.we_o), 32'(1));
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    tick;
    chk("midrst_we_after", 32'(bus.we_o), 32'(0));
    chk("midrst_addr", 32'(bus.addr_o), 32'(0));
    chk("midrst_mack1", 32'(bus.mem_ack), 32'(0));
    tick;
    rst            = 1'b0;
    bus.needWait_i = 1'b0;
    tick;
    chk("midrst_mack2", 32'(bus.mem_ack), 32'(0));
    chk("midrst_mrd", 32'(bus.mem_rdata), 32'(0));

    do_access("fetch_a5a5", 1'b1, 24'h000100, 1'b0, 16'h0,
              16'hA5A5, 0);
    do_access("mem_rd", 1'b0, 24'h000010, 1'b0, 16'h0,
              16'h1111, 0);

    // both requesters held: fetch forced after four mem grants
    pat            = "MMMMFMMMMF";
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h000200;
    bus.mem_req    = 1'b1;
    bus.mem_addr   = 24'h000300;
    bus.mem_we     = 1'b0;
    bus.needWait_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.data_i = 16'h3000 + 16'(i);
      e.is_fetch = (pat[i] == "F");
      e.rdata    = bus.data_i;
      e.err      = 1'b0;
      if (!e.is_fetch) exp_mem_rd = bus.data_i;
      sb.push_back(e);
      tick;
      chk($sformatf("starve_re%0d", i), 32'(bus.re_o), 32'(1));
      chk($sformatf("starve_addr%0d", i), 32'(bus.addr_o),
          e.is_fetch ? 32'h200 : 32'h300);
      tick;
      check_ack($sformatf("starve%0d", i));
    end
    bus.fetch_req = 1'b0;
    bus.mem_req   = 1'b0;
    tick;

    do_access("mem_wr_wait", 1'b0, 24'h00ABCD, 1'b1, 16'h1234,
              16'hBEEF, 3);
    do_access("mem_rd_top", 1'b0, 24'hFFFFFF, 1'b0, 16'h0,
              16'h5A5A, 1);
    do_access("fetch_wait", 1'b1, 24'h000000, 1'b0, 16'h0,
              16'h0001, 2);

    // stuck wait request
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h000400;
    bus.data_i     = 16'h7777;
    bus.needWait_i = 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
    e.is_fetch = 1'b1;
    e.rdata    = 16'hFFFF;
    e.err      = 1'b1;
    sb.push_back(e);
    tick;
    n = 0;
    while (!bus.fetch_ack && n < 300) begin
      tick;
      n++;
    end
    chk("to_cycles", 32'(n), 32'(255));
    check_ack("timeout");
    chk("to_re", 32'(bus.re_o), 32'(0));
    bus.fetch_req  = 1'b0;
    bus.needWait_i = 1'b0;
    tick;
`else
    tick;
    acks   = 0;
    re_low = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.fetch_ack || bus.mem_ack) acks++;
      if (!bus.re_o) re_low++;
      tick;
    end
    chk("nto_acks", 32'(acks), 32'(0));
    chk("nto_re_low", 32'(re_low), 32'(0));
    chk("nto_err", 32'(bus.bus_err), 32'(0));
    e.is_fetch = 1'b1;
    e.rdata    = 16'h7777;
    e.err      = 1'b0;
    sb.push_back(e);
    bus.needWait_i = 1'b0;
    tick;
    check_ack("nto_release");
    bus.fetch_req = 1'b0;
    tick;
`endif
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
